coreaxitoahbl_write_byte_cnt: RTL and testbench

- Write-direction counterpart of the read valid-byte lookup in the AXI-to-AHB-Lite bridge.
- Counts the bytes actually written in one AXI write burst by accumulating WSTRB beat by beat.
- Checks that every strobe is contiguous and that WLAST lands on the beat the AW length predicts.
- Reports the byte total and error flags to the AHB-side write sequencer.
- Sits between the AXI write-data channel and the bridge control FSM.

---
 rtl/coreaxitoahbl_write_byte_cnt_pkg.sv | 19 +
 rtl/coreaxitoahbl_strb_decode.sv | 38 +++
 rtl/coreaxitoahbl_write_byte_cnt.sv | 115 +++++++++++
 tb/tb_coreaxitoahbl_write_byte_cnt.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coreaxitoahbl_write_byte_cnt_pkg.sv
// Shared types and constants for the AXI-to-AHB-Lite write-direction byte counter.
// Holds the FSM state encoding, sizing constants and the strobe-width derivation.
package coreaxitoahbl_write_byte_cnt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } wbcState_t;

    localparam int MAX_BEATS = 16;
    localparam int CNT_W     = 8;
    localparam int BEAT_W    = 5;

    function automatic int strbWidth(input int dataWidth);
        return dataWidth / 8;
    endfunction

endpackage

// File: rtl/coreaxitoahbl_strb_decode.sv
// Combinational WSTRB decode: number of set strobe bits and whether they form one run.
// An all-zero strobe counts as contiguous.
module coreaxitoahbl_strb_decode
    import coreaxitoahbl_write_byte_cnt_pkg::*;
#(
    parameter int STRB_W = 8
) (
    input  logic [STRB_W-1:0] strb,
    output logic [3:0]        popCnt,
    output logic              contiguous
);

    logic [STRB_W-1:0] riseVec;
    logic [3:0]        riseCnt;

    // A run starts wherever a set bit has a clear (or no) neighbour below it.
    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_rise
            if (gi == 0) begin : g_lsb
                assign riseVec[gi] = strb[gi];
            end else begin : g_upper
                assign riseVec[gi] = strb[gi] & ~strb[gi-1];
            end
        end
    endgenerate

    always_comb begin
        popCnt  = '0;
        riseCnt = '0;
        for (int i = 0; i < STRB_W; i++) begin
            popCnt  = popCnt + {3'b000, strb[i]};
            riseCnt = riseCnt + {3'b000, riseVec[i]};
        end
        contiguous = (riseCnt <= 4'd1);
    end

endmodule

// File: rtl/coreaxitoahbl_write_byte_cnt.sv
// Counts the bytes written in one AXI write burst from WSTRB and flags strobe gaps
// and WLAST placement that disagrees with the AW length.
module coreaxitoahbl_write_byte_cnt
    import coreaxitoahbl_write_byte_cnt_pkg::*;
#(
    parameter  int AXI_DWIDTH = 64,
    localparam int STRB_W     = strbWidth(AXI_DWIDTH)
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              start,
    input  logic [3:0]        burstLen,
    input  logic [STRB_W-1:0] WSTRB,
    input  logic              WVALID,
    input  logic              WREADY,
    input  logic              WLAST,
    output logic              wAccept,
    output logic [CNT_W-1:0]  validBytes,
    output logic [BEAT_W-1:0] beatCnt,
    output logic              cntDone,
    output logic              strbError,
    output logic              lenError
);

    wbcState_t         stateReg, stateNext;
    logic [3:0]        lenReg;
    logic [CNT_W-1:0]  accReg;
    logic [BEAT_W-1:0] beatCntReg;
    logic [CNT_W-1:0]  validBytesReg;
    logic              cntDoneReg;
    logic              strbErrReg;
    logic              lenErrReg;

    logic [3:0]        popCnt;
    logic              contiguous;
    logic              beat;
    logic              atLenBeat;
    logic              finalBeat;
    logic              arm;
    logic [BEAT_W-1:0] beatNum;
    logic [BEAT_W-1:0] lenPlusOne;
    logic [CNT_W-1:0]  accSum;

    coreaxitoahbl_strb_decode #(
        .STRB_W (STRB_W)
    ) u_strb_decode (
        .strb       (WSTRB),
        .popCnt     (popCnt),
        .contiguous (contiguous)
    );

    assign beat       = WVALID && WREADY && (stateReg == ACCUM);
    assign beatNum    = beatCntReg + 5'd1;
    assign lenPlusOne = {1'b0, lenReg} + 5'd1;
    assign atLenBeat  = (beatNum == lenPlusOne);
    assign finalBeat  = beat && (WLAST || atLenBeat);
    assign accSum     = accReg + {4'b0000, popCnt};
    // start is only honoured outside ACCUM; the bridge never issues it mid-burst.
    assign arm        = start && (stateReg != ACCUM);

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (start) stateNext = ACCUM;
            ACCUM:   if (finalBeat) stateNext = DONE;
            DONE:    stateNext = start ? ACCUM : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            stateReg      <= IDLE;
            lenReg        <= '0;
            accReg        <= '0;
            beatCntReg    <= '0;
            validBytesReg <= '0;
            cntDoneReg    <= 1'b0;
            strbErrReg    <= 1'b0;
            lenErrReg     <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            cntDoneReg <= 1'b0;
            if (arm) begin
                lenReg     <= burstLen;
                accReg     <= '0;
                beatCntReg <= '0;
                strbErrReg <= 1'b0;
                lenErrReg  <= 1'b0;
            end else if (beat) begin
                accReg     <= accSum;
                beatCntReg <= beatNum;
                if (!contiguous) begin
                    strbErrReg <= 1'b1;
                end
                // Error both for an early WLAST and for a missing WLAST on the last beat.
                if (WLAST != atLenBeat) begin
                    lenErrReg <= 1'b1;
                end
                if (finalBeat) begin
                    validBytesReg <= accSum;
                    cntDoneReg    <= 1'b1;
                end
            end
        end
    end

    assign wAccept    = (stateReg == ACCUM);
    assign validBytes = validBytesReg;
    assign beatCnt    = beatCntReg;
    assign cntDone    = cntDoneReg;
    assign strbError  = strbErrReg;
    assign lenError   = lenErrReg;

endmodule

// File: tb/tb_coreaxitoahbl_write_byte_cnt.sv
// Scoreboard bench: 64-bit and 32-bit instances share one stimulus stream; a burst-level
// reference model queues expected results and a negedge monitor checks each cntDone.
module tb_coreaxitoahbl_write_byte_cnt;

    logic       clk = 1'b0;
    logic       ARESET, start, WVALID, WREADY, WLAST;
    logic [3:0] burstLen;
    logic [7:0] strb;

    logic       wAccept64, cntDone64, strbError64, lenError64;
    logic [7:0] validBytes64;
    logic [4:0] beatCnt64;
    logic       wAccept32, cntDone32, strbError32, lenError32;
    logic [7:0] validBytes32;
    logic [4:0] beatCnt32;

    always #5 clk = ~clk;

    coreaxitoahbl_write_byte_cnt #(.AXI_DWIDTH(64)) dut64 (
        .ACLK(clk), .ARESET(ARESET), .start(start), .burstLen(burstLen),
        .WSTRB(strb), .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
        .wAccept(wAccept64), .validBytes(validBytes64), .beatCnt(beatCnt64),
        .cntDone(cntDone64), .strbError(strbError64), .lenError(lenError64)
    );

    coreaxitoahbl_write_byte_cnt #(.AXI_DWIDTH(32)) dut32 (
        .ACLK(clk), .ARESET(ARESET), .start(start), .burstLen(burstLen),
        .WSTRB(strb[3:0]), .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
        .wAccept(wAccept32), .validBytes(validBytes32), .beatCnt(beatCnt32),
        .cntDone(cntDone32), .strbError(strbError32), .lenError(lenError32)
    );

    typedef struct {
        int bytes64;
        int bytes32;
        bit se64;
        bit se32;
        bit le;
        int beats;
        int cyc;
    } exp_t;

    exp_t       expQ[$];
    exp_t       monE;
    int         vectors = 0;
    int         miscompares = 0;
    int         cycle = 0;
    logic [7:0] bStrb[32];
    bit         bLast[32];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cycle);
        end
    endtask

    function automatic int refPop(input logic [7:0] s, input int w);
        int n = 0;
        for (int i = 0; i < w; i++) if (s[i]) n++;
        return n;
    endfunction

    function automatic bit refContig(input logic [7:0] s, input int w);
        int lo = -1, hi = -1, n = 0;
        for (int i = 0; i < w; i++) begin
            if (s[i]) begin
                if (lo < 0) lo = i;
                hi = i;
                n++;
            end
        end
        return (n == 0) || (n == hi - lo + 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        check({tag, "_wAccept64"}, wAccept64, 0);
        check({tag, "_validBytes64"}, validBytes64, 0);
        check({tag, "_beatCnt64"}, beatCnt64, 0);
        check({tag, "_cntDone64"}, cntDone64, 0);
        check({tag, "_strbError64"}, strbError64, 0);
        check({tag, "_lenError64"}, lenError64, 0);
        check({tag, "_wAccept32"}, wAccept32, 0);
        check({tag, "_validBytes32"}, validBytes32, 0);
        check({tag, "_cntDone32"}, cntDone32, 0);
    endtask

    task automatic clearBeats();
        for (int i = 0; i < 32; i++) begin
            bStrb[i] = 8'h00;
            bLast[i] = 1'b0;
        end
    endtask

    // Idle cycles with random, ignored handshakes; the block is never in ACCUM here.
    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            WVALID = 1'($urandom_range(0, 1));
            WREADY = 1'($urandom_range(0, 1));
            strb   = 8'($urandom);
            WLAST  = 1'($urandom_range(0, 1));
            check("idle_wAccept64", wAccept64, 0);
            tick();
        end
        WVALID = 1'b0; WREADY = 1'b0; WLAST = 1'b0;
    endtask

    // One burst: the model decides which beat terminates it and what the totals are.
    task automatic doBurst(input int len, input int extra);
        exp_t e;
        int   term;
        term = len;
        for (int i = len; i >= 0; i--) if (bLast[i]) term = i;
        e.bytes64 = 0; e.bytes32 = 0; e.se64 = 0; e.se32 = 0;
        for (int i = 0; i <= term; i++) begin
            e.bytes64 += refPop(bStrb[i], 8);
            e.bytes32 += refPop(bStrb[i], 4);
            if (!refContig(bStrb[i], 8)) e.se64 = 1;
            if (!refContig(bStrb[i], 4)) e.se32 = 1;
        end
        e.le    = !(bLast[term] && term == len);
        e.beats = term + 1;

        start = 1'b1; burstLen = 4'(len); WVALID = 1'b0; WREADY = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i <= term; i++) begin
            repeat ($urandom_range(0, 2)) begin
                WVALID = 1'($urandom_range(0, 1));
                WREADY = ~WVALID;
                strb   = 8'($urandom);
                WLAST  = 1'($urandom_range(0, 1));
                tick();
            end
            WVALID = 1'b1; WREADY = 1'b1; strb = bStrb[i]; WLAST = bLast[i];
            check("beat_wAccept64", wAccept64, 1);
            check("beat_wAccept32", wAccept32, 1);
            tick();
        end
        e.cyc = cycle;
        expQ.push_back(e);
        for (int k = 0; k < extra; k++) begin
            WVALID = 1'b1; WREADY = 1'b1; strb = 8'($urandom); WLAST = 1'($urandom_range(0, 1));
            tick();
        end
        WVALID = 1'b0; WREADY = 1'b0; WLAST = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cntDone64 || cntDone32) begin
            if (expQ.size() == 0) begin
                check("unexpected_cntDone", 1, 0);
            end else begin
                monE = expQ.pop_front();
                check("cntDone64", cntDone64, 1);
                check("cntDone32", cntDone32, 1);
                check("done_latency", cycle, monE.cyc);
                check("validBytes64", validBytes64, monE.bytes64);
                check("validBytes32", validBytes32, monE.bytes32);
                check("strbError64", strbError64, monE.se64);
                check("strbError32", strbError32, monE.se32);
                check("lenError64", lenError64, monE.le);
                check("lenError32", lenError32, monE.le);
                check("beatCnt64", beatCnt64, monE.beats);
                check("beatCnt32", beatCnt32, monE.beats);
                check("done_wAccept64", wAccept64, 0);
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, mode, k, lo, n, extra;
        ARESET = 1'b1; start = 1'b0; burstLen = 4'd0; strb = 8'h00;
        WVALID = 1'b0; WREADY = 1'b0; WLAST = 1'b0;
        repeat (3) tick();
        checkIdle("reset");
        ARESET = 1'b0;
        tick();

        // Four full beats, WLAST on the fourth.
        clearBeats();
        for (int i = 0; i < 4; i++) bStrb[i] = 8'hFF;
        bLast[3] = 1'b1;
        doBurst(3, 0);
        idleCycles(2);

        // Leading partial strobe: 0xF0 then three full beats.
        clearBeats();
        bStrb[0] = 8'hF0; bStrb[1] = 8'hFF; bStrb[2] = 8'hFF; bStrb[3] = 8'hFF;
        bLast[3] = 1'b1;
        doBurst(3, 0);
        idleCycles(2);

        // A handshake before start must be ignored, then a single two-byte beat.
        WVALID = 1'b1; WREADY = 1'b1; strb = 8'hFF; WLAST = 1'b1;
        check("preStart_wAccept32", wAccept32, 0);
        tick();
        WVALID = 1'b0; WREADY = 1'b0; WLAST = 1'b0;
        tick();
        check("preStart_cntDone64", cntDone64, 0);
        clearBeats();
        bStrb[0] = 8'h03; bLast[0] = 1'b1;
        doBurst(0, 0);
        idleCycles(2);

        // Non-contiguous strobe.
        clearBeats();
        bStrb[0] = 8'hA5; bStrb[1] = 8'hFF; bLast[1] = 1'b1;
        doBurst(1, 0);
        idleCycles(2);

        // Early WLAST on beat 2 of 4.
        clearBeats();
        bStrb[0] = 8'hFF; bStrb[1] = 8'hFF; bLast[1] = 1'b1;
        doBurst(3, 0);
        idleCycles(2);

        // Missing WLAST on the last beat; a third beat follows and is dropped.
        clearBeats();
        bStrb[0] = 8'hFF; bStrb[1] = 8'h0F;
        doBurst(1, 1);
        idleCycles(2);

        // Reset asserted during beat 2 of 4.
        start = 1'b1; burstLen = 4'd3;
        tick();
        start = 1'b0;
        WVALID = 1'b1; WREADY = 1'b1; strb = 8'hFF; WLAST = 1'b0;
        tick();
        ARESET = 1'b1;
        tick();
        checkIdle("midReset");
        ARESET = 1'b0; WVALID = 1'b0; WREADY = 1'b0;
        tick();
        checkIdle("afterReset");

        // Back-to-back bursts: start issued in the DONE cycle.
        clearBeats();
        bStrb[0] = 8'h0F; bStrb[1] = 8'hF0; bLast[1] = 1'b1;
        doBurst(1, 0);
        clearBeats();
        bStrb[0] = 8'h3C; bLast[0] = 1'b1;
        doBurst(0, 0);
        idleCycles(2);

        // Randomized bursts.
        for (int b = 0; b < 300; b++) begin
            clearBeats();
            len  = $urandom_range(0, 15);
            mode = $urandom_range(0, 3);
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    bStrb[i] = 8'($urandom);
                end else begin
                    lo = $urandom_range(0, 7);
                    n  = $urandom_range(0, 8 - lo);
                    bStrb[i] = 8'(((1 << n) - 1) << lo);
                end
            end
            if (mode <= 1) begin
                bLast[len] = 1'b1;
            end else if (mode == 2) begin
                k = $urandom_range(0, len);
                bLast[k] = 1'b1;
            end
            extra = (mode == 3) ? $urandom_range(0, 2) : 0;
            doBurst(len, extra);
            if (extra != 0 || $urandom_range(0, 1) == 0) begin
                idleCycles($urandom_range(1, 3));
            end
        end

        idleCycles(4);
        check("scoreboard_empty", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
